div_sequencer: RTL and testbench

- Multi-cycle controller for the processor's 32-bit restoring divider.
- Latches dividend and divisor on a start request, then steps the shift/subtract/restore iteration once per clock for WIDTH cycles.
- Detects divide-by-zero and presents quotient, remainder and a one-cycle ready pulse to the pipeline stall/writeback logic.
- Sits between the execute stage's div issue and writeback; owns the AQ working register and the iteration counter.

---
 rtl/div_sequencer_pkg.sv | 18 +
 rtl/div_step.sv | 30 +++
 rtl/div_sequencer.sv | 178 +++++++++++++++++
 tb/tb_div_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the multi-cycle restoring divider sequencer.
// Optional signed operation is selected with the DIV_SIGNED_EN macro.
package div_sequencer_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = 6;

    // Every quotient bit reported on divide by zero takes this value (all ones).
    localparam logic DIV_ZERO_FILL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift AQ left, trial-subtract M, restore on borrow.
// The trial subtract is one bit wider than A so the borrow is exact for any divisor.
module div_step
    import div_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   a_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH:0]   a_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH+1:0] a_sh;
    logic [WIDTH+1:0] diff;

    always_comb begin
        a_sh = {a_i, q_i[WIDTH-1]};
        diff = a_sh - (WIDTH+2)'(m_i);
        if (diff[WIDTH+1]) begin
            a_o = a_sh[WIDTH:0];
            q_o = {q_i[WIDTH-2:0], 1'b0};
        end else begin
            a_o = diff[WIDTH:0];
            q_o = {q_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider controller: latches operands, runs WIDTH steps, reports results.
// Define DIV_SIGNED_EN for two's-complement operands (truncating division); default is unsigned.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = DIV_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_exception
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             exc_q, exc_d;
`ifdef DIV_SIGNED_EN
    logic             sgn_quot_q, sgn_quot_d;
    logic             sgn_rem_q, sgn_rem_d;
`endif

    logic [WIDTH:0]   step_a;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] quot_mag;
    logic [WIDTH-1:0] rem_mag;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a_i (a_q),
        .q_i (q_q),
        .m_i (m_q),
        .a_o (step_a),
        .q_o (step_q)
    );

    // Operand magnitudes fed into the unsigned core
    always_comb begin
`ifdef DIV_SIGNED_EN
        dvd_mag = dividend[WIDTH-1] ? (WIDTH'(0) - dividend) : dividend;
        dvs_mag = divisor[WIDTH-1]  ? (WIDTH'(0) - divisor)  : divisor;
`else
        dvd_mag = dividend;
        dvs_mag = divisor;
`endif
    end

    // Next-state, datapath and output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        q_d      = q_q;
        m_d      = m_q;
        dz_d     = dz_q;
        busy_d   = busy_q;
        ready_d  = 1'b0;
        quot_d   = quot_q;
        rem_d    = rem_q;
        exc_d    = exc_q;
`ifdef DIV_SIGNED_EN
        sgn_quot_d = sgn_quot_q;
        sgn_rem_d  = sgn_rem_q;
`endif
        // On divide by zero Q still holds the (magnitude of the) dividend
        quot_mag = q_q;
        rem_mag  = dz_q ? q_q : a_q[WIDTH-1:0];

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d    = '0;
                    q_d    = dvd_mag;
                    m_d    = dvs_mag;
                    dz_d   = (divisor == '0);
                    cnt_d  = '0;
                    exc_d  = 1'b0;
                    busy_d = 1'b1;
`ifdef DIV_SIGNED_EN
                    sgn_quot_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    sgn_rem_d  = dividend[WIDTH-1];
`endif
                    state_d = (divisor == '0) ? ST_FIXUP : ST_RUN;
                end
            end
            ST_RUN: begin
                a_d   = step_a;
                q_d   = step_q;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == CNT_W'(WIDTH)) begin
                    state_d = ST_FIXUP;
                end
            end
            ST_FIXUP: begin
`ifdef DIV_SIGNED_EN
                quot_d = sgn_quot_q ? (WIDTH'(0) - quot_mag) : quot_mag;
                rem_d  = sgn_rem_q  ? (WIDTH'(0) - rem_mag)  : rem_mag;
`else
                quot_d = quot_mag;
                rem_d  = rem_mag;
`endif
                if (dz_q) begin
                    quot_d = {WIDTH{DIV_ZERO_FILL}};
                end
                exc_d   = dz_q;
                busy_d  = 1'b0;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            exc_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            sgn_quot_q <= 1'b0;
            sgn_rem_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            exc_q   <= exc_d;
`ifdef DIV_SIGNED_EN
            sgn_quot_q <= sgn_quot_d;
            sgn_rem_q  <= sgn_rem_d;
`endif
        end
    end

    assign busy          = busy_q;
    assign ready         = ready_q;
    assign quotient      = quot_q;
    assign remainder     = rem_q;
    assign div_exception = exc_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: directed operands with hand-computed results and latencies.
// Expected values follow the DIV_SIGNED_EN setting of the build.
module tb_div_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_exception;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
        int          rc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    localparam int LAT    = 34;
    localparam int LAT_DZ = 2;

    div_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .dividend      (dividend),
        .divisor       (divisor),
        .busy          (busy),
        .ready         (ready),
        .quotient      (quotient),
        .remainder     (remainder),
        .div_exception (div_exception)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every ready pulse
    always @(negedge clock) begin
        exp_t e;
        if (ready) begin
            if (sb.size() == 0) begin
                check("spurious ready", 32'(ready), 32'(0));
            end else begin
                e = sb.pop_front();
                check({e.name, " quotient"}, quotient, e.q);
                check({e.name, " remainder"}, remainder, e.r);
                check({e.name, " exception"}, 32'(div_exception), 32'(e.e));
                check({e.name, " ready cycle"}, 32'(cyc), 32'(e.rc));
            end
        end else if (sb.size() > 0 && cyc > sb[0].rc) begin
            e = sb.pop_front();
            check({e.name, " ready missing"}, 32'(cyc), 32'(e.rc));
        end
    end

    task automatic run_op(input string name, input logic [31:0] dd, input logic [31:0] dv,
                          input logic [31:0] eq, input logic [31:0] er, input logic ee,
                          input int lat, input bit chk_busy);
        exp_t e;
        bit   seen;
        @(negedge clock);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        e.q = eq; e.r = er; e.e = ee; e.rc = cyc + 1 + lat; e.name = name;
        sb.push_back(e);
        seen = 1'b0;
        for (int k = 0; k < lat + 20 && !seen; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (chk_busy && k <= lat)
                check({name, " busy"}, 32'(busy), 32'(k <= lat - 2));
            if (ready) seen = 1'b1;
        end
        if (!seen) check({name, " ready timeout"}, 32'(0), 32'(1));
    endtask

    task automatic wait_ready(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clock);
            if (ready) seen = 1'b1;
        end
        if (!seen) check({name, " ready timeout"}, 32'(0), 32'(1));
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, " busy"}, 32'(busy), 32'(0));
        check({name, " ready"}, 32'(ready), 32'(0));
        check({name, " quotient"}, quotient, 32'h0);
        check({name, " remainder"}, remainder, 32'h0);
        check({name, " exception"}, 32'(div_exception), 32'(0));
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check_zero_outputs("reset");
        reset = 1'b0;

        run_op("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT, 1'b1);
`ifdef DIV_SIGNED_EN
        run_op("large", 32'hFFFFFFFF, 32'h80000001, 32'h0, 32'hFFFFFFFF, 1'b0, LAT, 1'b0);
`else
        run_op("large", 32'hFFFFFFFF, 32'h80000001, 32'h1, 32'h7FFFFFFE, 1'b0, LAT, 1'b0);
`endif
        run_op("div0", 32'h12345678, 32'h0, 32'hFFFFFFFF, 32'h12345678, 1'b1, LAT_DZ, 1'b1);
        run_op("div0 neg", 32'h80000005, 32'h0, 32'hFFFFFFFF, 32'h80000005, 1'b1, LAT_DZ, 1'b0);
`ifdef DIV_SIGNED_EN
        run_op("-7/2", 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, LAT, 1'b0);
        run_op("min/-1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0, LAT, 1'b0);
`else
        run_op("-7/2", 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'h1, 1'b0, LAT, 1'b0);
        run_op("min/-1", 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, LAT, 1'b0);
`endif
        run_op("all1/1", 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'h0, 1'b0, LAT, 1'b0);
        run_op("7/9", 32'd7, 32'd9, 32'h0, 32'd7, 1'b0, LAT, 1'b0);

        // Start while busy is ignored; start right after ready is accepted
        begin
            exp_t e;
            @(negedge clock);
            start = 1'b1; dividend = 32'd1000; divisor = 32'd10;
            e.q = 32'd100; e.r = 32'd0; e.e = 1'b0; e.rc = cyc + 1 + LAT; e.name = "busy-start";
            sb.push_back(e);
            @(negedge clock);
            start = 1'b0;
            repeat (9) @(negedge clock);
            start = 1'b1; dividend = 32'd5; divisor = 32'd5;
            @(negedge clock);
            start = 1'b0;
            check("busy during op", 32'(busy), 32'(1));
            wait_ready("busy-start");
        end
        run_op("b2b 64/64", 32'h64, 32'h64, 32'd1, 32'd0, 1'b0, LAT, 1'b0);

        // Reset mid-operation aborts, and wins over a simultaneous start
        @(negedge clock);
        start = 1'b1; dividend = 32'd77; divisor = 32'd5;
        @(negedge clock);
        start = 1'b0;
        repeat (13) @(negedge clock);
        reset = 1'b1;
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
        @(negedge clock);
        check_zero_outputs("abort");
        reset = 1'b0;
        start = 1'b0;
        repeat (40) @(negedge clock);
        check("abort idle busy", 32'(busy), 32'(0));
        run_op("9/3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, LAT, 1'b1);

        repeat (5) @(negedge clock);
        check("scoreboard drained", 32'(sb.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
